// File: rtl/abm_pkg.sv
// Shared definitions for the ABM RAM writer: AXI response/burst codes and the
// write-path FSM state encoding.
package abm_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/abm_writer_if.sv
// AXI4 write-only slave filling the two ABM SDP RAMs; address bit AW-1 picks the RAM.
// Optional macro ABM_WSTRB_EN enables byte-granular writes from WSTRB.
module abm_writer_if
   import abm_pkg::*;
#(
   parameter int DW = 512,
   parameter int DD = 16384,
   parameter int AW = $clog2(DD * (DW / 8)) + 1
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic [AW-1:0]         S_AXI_AWADDR,
   input  logic                  S_AXI_AWVALID,
   output logic                  S_AXI_AWREADY,
   input  logic [3:0]            S_AXI_AWID,
   input  logic [7:0]            S_AXI_AWLEN,
   input  logic [2:0]            S_AXI_AWSIZE,
   input  logic [1:0]            S_AXI_AWBURST,

   input  logic [DW-1:0]         S_AXI_WDATA,
   input  logic [DW/8-1:0]       S_AXI_WSTRB,
   input  logic                  S_AXI_WVALID,
   output logic                  S_AXI_WREADY,
   input  logic                  S_AXI_WLAST,

   output logic [3:0]            S_AXI_BID,
   output logic [1:0]            S_AXI_BRESP,
   output logic                  S_AXI_BVALID,
   input  logic                  S_AXI_BREADY,

   output logic [$clog2(DD)-1:0] ram_addr,
   output logic [DW-1:0]         ram_wdata,
   output logic [DW/8-1:0]       ram0_we,
   output logic [DW/8-1:0]       ram1_we
);

   localparam int SB  = DW / 8;
   localparam int OFF = $clog2(SB);
   localparam int AAW = $clog2(DD);

   state_e          state_q, state_d;
   logic            awready_q, awready_d;
   logic            wready_q, wready_d;
   logic            bvalid_q, bvalid_d;
   logic [1:0]      bresp_q, bresp_d;
   logic [3:0]      bid_q, bid_d;
   logic [3:0]      id_q, id_d;
   logic [7:0]      len_q, len_d;
   logic [7:0]      beat_q, beat_d;
   logic [AAW-1:0]  addr_q, addr_d;
   logic            sel_q, sel_d;
   logic            aw_err_q, aw_err_d;
   logic            wl_err_q, wl_err_d;
   logic [AAW-1:0]  ram_addr_q, ram_addr_d;
   logic [DW-1:0]   ram_wdata_q, ram_wdata_d;
   logic [SB-1:0]   ram0_we_q, ram0_we_d;
   logic [SB-1:0]   ram1_we_q, ram1_we_d;

   logic [SB-1:0]   beat_we;
   logic            last_beat;
   logic            wlast_bad;
   logic            unused_ok;

`ifdef ABM_WSTRB_EN
   assign beat_we   = S_AXI_WSTRB;
   assign unused_ok = ^S_AXI_AWADDR[OFF-1:0];
`else
   // Full-word writes only: the strobes are accepted on the bus but never used.
   assign beat_we   = '1;
   assign unused_ok = ^{S_AXI_AWADDR[OFF-1:0], S_AXI_WSTRB};
`endif

   assign last_beat = (beat_q == len_q);
   assign wlast_bad = (S_AXI_WLAST != last_beat);

   // NOTE: every variable gets its hold/default value first so no path through
   // the case statement can leave it unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      bresp_d     = bresp_q;
      bid_d       = bid_q;
      id_d        = id_q;
      len_d       = len_q;
      beat_d      = beat_q;
      addr_d      = addr_q;
      sel_d       = sel_q;
      aw_err_d    = aw_err_q;
      wl_err_d    = wl_err_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram0_we_d   = '0;
      ram1_we_d   = '0;

      case (state_q)
         IDLE: begin
            if (awready_q && S_AXI_AWVALID) begin
               addr_d   = S_AXI_AWADDR[OFF +: AAW];
               sel_d    = S_AXI_AWADDR[AW-1];
               len_d    = S_AXI_AWLEN;
               id_d     = S_AXI_AWID;
               aw_err_d = (S_AXI_AWBURST != BURST_INCR) || (S_AXI_AWSIZE != 3'(OFF));
               wl_err_d = 1'b0;
               beat_d   = '0;
               state_d  = DATA;
            end
         end

         DATA: begin
            if (wready_q && S_AXI_WVALID) begin
               wl_err_d = wl_err_q | wlast_bad;
               // A misplaced WLAST only poisons the response; data is still written.
               if (!aw_err_q) begin
                  ram_addr_d  = addr_q;
                  ram_wdata_d = S_AXI_WDATA;
                  if (sel_q) ram1_we_d = beat_we;
                  else       ram0_we_d = beat_we;
               end
               addr_d = (addr_q == AAW'(DD - 1)) ? '0 : addr_q + 1'b1;
               beat_d = beat_q + 8'd1;
               if (last_beat) begin
                  bresp_d = (aw_err_q || wl_err_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                  bid_d   = id_q;
                  state_d = RESP;
               end
            end
         end

         RESP: begin
            if (bvalid_q && S_AXI_BREADY) state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase

      // Handshake readies are registered so they sit low throughout reset.
      awready_d = (state_d == IDLE);
      wready_d  = (state_d == DATA);
      bvalid_d  = (state_d == RESP);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         awready_q   <= 1'b0;
         wready_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         bresp_q     <= RESP_OKAY;
         bid_q       <= '0;
         id_q        <= '0;
         len_q       <= '0;
         beat_q      <= '0;
         addr_q      <= '0;
         sel_q       <= 1'b0;
         aw_err_q    <= 1'b0;
         wl_err_q    <= 1'b0;
         ram_addr_q  <= '0;
         // NOTE: the wide write-data register is reset so the RAM ports present a
         // known value from reset; it is a pipeline register, not storage.
         ram_wdata_q <= '0;
         ram0_we_q   <= '0;
         ram1_we_q   <= '0;
      end else begin
         state_q     <= state_d;
         awready_q   <= awready_d;
         wready_q    <= wready_d;
         bvalid_q    <= bvalid_d;
         bresp_q     <= bresp_d;
         bid_q       <= bid_d;
         id_q        <= id_d;
         len_q       <= len_d;
         beat_q      <= beat_d;
         addr_q      <= addr_d;
         sel_q       <= sel_d;
         aw_err_q    <= aw_err_d;
         wl_err_q    <= wl_err_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram0_we_q   <= ram0_we_d;
         ram1_we_q   <= ram1_we_d;
      end
   end

   assign S_AXI_AWREADY = awready_q;
   assign S_AXI_WREADY  = wready_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_BID     = bid_q;
   assign ram_addr      = ram_addr_q;
   assign ram_wdata     = ram_wdata_q;
   assign ram0_we       = ram0_we_q;
   assign ram1_we       = ram1_we_q;

endmodule
